// File: rtl/eth_demux_if.sv
// Frame bundle (Ethernet header + AXI-stream payload) for N parallel lanes.
// Lane i of a field lives at [i*W +: W]. The master drives the header and payload; the slave drives the readies.
interface eth_demux_if #(
   parameter int N          = 1,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = 1,
   parameter int USER_WIDTH = 1
);
   logic [N-1:0]            hdr_valid;
   logic [N-1:0]            hdr_ready;
   logic [N*48-1:0]         dest_mac;
   logic [N*48-1:0]         src_mac;
   logic [N*16-1:0]         eth_type;
   logic [N*DATA_WIDTH-1:0] tdata;
   logic [N*KEEP_WIDTH-1:0] tkeep;
   logic [N-1:0]            tvalid;
   logic [N-1:0]            tready;
   logic [N-1:0]            tlast;
   logic [N*USER_WIDTH-1:0] tuser;

   modport master (
      output hdr_valid, dest_mac, src_mac, eth_type,
      output tdata, tkeep, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, dest_mac, src_mac, eth_type,
      input  tdata, tkeep, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/eth_demux.sv
// Frame demux: routes one header/payload stream to the port named by select. The header is registered (ready and valid 1 cycle after hdr_valid); the payload goes through a 2-deep skid, so it lags the input by 1 cycle.
// Input tready falls at most 1 cycle after the selected port stalls. Defining ETH_DEMUX_DROP_EN adds a drop input that discards a whole frame.
module eth_demux #(
   parameter int M_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter bit USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1,
   localparam int CL_M_COUNT = $clog2(M_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   eth_demux_if.slave            s_eth,
   eth_demux_if.master           m_eth,
   input  logic                  enable,
   input  logic [CL_M_COUNT-1:0] select
`ifdef ETH_DEMUX_DROP_EN
   ,
   input  logic                  drop
`endif
);

   typedef enum logic {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

   state_t                  state_reg, state_next;
   logic [CL_M_COUNT-1:0]   select_reg, select_next;
   logic                    drop_reg, drop_next;
   logic                    hdr_ready_reg, hdr_ready_next;
   logic [M_COUNT-1:0]      hdr_valid_reg, hdr_valid_next;
   logic [47:0]             dest_mac_reg, dest_mac_next;
   logic [47:0]             src_mac_reg, src_mac_next;
   logic [15:0]             eth_type_reg, eth_type_next;

   logic                    tready_int_reg, tready_int_early;
   logic [M_COUNT-1:0]      tvalid_int;
   logic [M_COUNT-1:0]      out_tvalid_reg, out_tvalid_next;
   logic [M_COUNT-1:0]      tmp_tvalid_reg, tmp_tvalid_next;
   logic [DATA_WIDTH-1:0]   out_tdata_reg, tmp_tdata_reg;
   logic [KEEP_WIDTH-1:0]   out_tkeep_reg, tmp_tkeep_reg;
   logic                    out_tlast_reg, tmp_tlast_reg;
   logic [USER_WIDTH-1:0]   out_tuser_reg, tmp_tuser_reg;
   logic                    store_int_to_out, store_int_to_tmp, store_tmp_to_out;

   logic                    drop_sel, select_oob;
   logic                    in_xfer, in_eof, hdr_free, accept, out_consumed;

`ifdef ETH_DEMUX_DROP_EN
   assign drop_sel = drop;
`else
   assign drop_sel = 1'b0;
`endif

   generate
      if (M_COUNT == (1 << CL_M_COUNT)) begin : g_pow2
         assign select_oob = 1'b0;
      end else begin : g_npow2
         localparam logic [CL_M_COUNT:0] SEL_LIMIT = M_COUNT[CL_M_COUNT:0];
         assign select_oob = ({1'b0, select} >= SEL_LIMIT);
      end
   endgenerate

   assign in_xfer  = s_eth.tvalid[0] && s_eth.tready[0];
   assign in_eof   = in_xfer && s_eth.tlast[0];
   assign hdr_free = ((hdr_valid_reg & ~m_eth.hdr_ready) == '0);
   // A header may be taken in the same cycle the previous frame's tlast goes by.
   assign accept   = s_eth.hdr_valid[0] && enable && hdr_free && !hdr_ready_reg &&
                     ((state_reg == ST_IDLE) || in_eof);

   always_comb begin
      state_next     = state_reg;
      select_next    = select_reg;
      drop_next      = drop_reg;
      hdr_ready_next = 1'b0;
      hdr_valid_next = hdr_valid_reg & ~m_eth.hdr_ready;
      dest_mac_next  = dest_mac_reg;
      src_mac_next   = src_mac_reg;
      eth_type_next  = eth_type_reg;

      if (in_eof) begin
         state_next = ST_IDLE;
         drop_next  = 1'b0;
      end

      if (accept) begin
         state_next     = ST_FRAME;
         select_next    = select;
         drop_next      = drop_sel || select_oob;
         hdr_ready_next = 1'b1;
         dest_mac_next  = s_eth.dest_mac[47:0];
         src_mac_next   = s_eth.src_mac[47:0];
         eth_type_next  = s_eth.eth_type[15:0];
         if (!(drop_sel || select_oob)) begin
            hdr_valid_next[select] = 1'b1;
         end
      end
   end

   // Dropped frames are still consumed; their beats simply carry no valid bit.
   always_comb begin
      tvalid_int = '0;
      if (in_xfer && !drop_reg) begin
         tvalid_int[select_reg] = 1'b1;
      end
   end

   assign out_consumed     = |(m_eth.tready & out_tvalid_reg);
   assign tready_int_early = out_consumed ||
                             (!(|tmp_tvalid_reg) && (!(|out_tvalid_reg) || !(|tvalid_int)));

   always_comb begin
      out_tvalid_next  = out_tvalid_reg;
      tmp_tvalid_next  = tmp_tvalid_reg;
      store_int_to_out = 1'b0;
      store_int_to_tmp = 1'b0;
      store_tmp_to_out = 1'b0;
      if (tready_int_reg) begin
         if (out_consumed || !(|out_tvalid_reg)) begin
            out_tvalid_next  = tvalid_int;
            store_int_to_out = 1'b1;
         end else begin
            tmp_tvalid_next  = tvalid_int;
            store_int_to_tmp = 1'b1;
         end
      end else if (out_consumed) begin
         out_tvalid_next  = tmp_tvalid_reg;
         tmp_tvalid_next  = '0;
         store_tmp_to_out = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         select_reg     <= '0;
         drop_reg       <= 1'b0;
         hdr_ready_reg  <= 1'b0;
         hdr_valid_reg  <= '0;
         dest_mac_reg   <= '0;
         src_mac_reg    <= '0;
         eth_type_reg   <= '0;
         tready_int_reg <= 1'b0;
         out_tvalid_reg <= '0;
         tmp_tvalid_reg <= '0;
         out_tdata_reg  <= '0;
         out_tkeep_reg  <= '0;
         out_tlast_reg  <= 1'b0;
         out_tuser_reg  <= '0;
         tmp_tdata_reg  <= '0;
         tmp_tkeep_reg  <= '0;
         tmp_tlast_reg  <= 1'b0;
         tmp_tuser_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         select_reg     <= select_next;
         drop_reg       <= drop_next;
         hdr_ready_reg  <= hdr_ready_next;
         hdr_valid_reg  <= hdr_valid_next;
         dest_mac_reg   <= dest_mac_next;
         src_mac_reg    <= src_mac_next;
         eth_type_reg   <= eth_type_next;
         tready_int_reg <= tready_int_early;
         out_tvalid_reg <= out_tvalid_next;
         tmp_tvalid_reg <= tmp_tvalid_next;

         if (store_int_to_out) begin
            out_tdata_reg <= s_eth.tdata[DATA_WIDTH-1:0];
            out_tkeep_reg <= s_eth.tkeep[KEEP_WIDTH-1:0];
            out_tlast_reg <= s_eth.tlast[0];
            out_tuser_reg <= s_eth.tuser[USER_WIDTH-1:0];
         end else if (store_tmp_to_out) begin
            out_tdata_reg <= tmp_tdata_reg;
            out_tkeep_reg <= tmp_tkeep_reg;
            out_tlast_reg <= tmp_tlast_reg;
            out_tuser_reg <= tmp_tuser_reg;
         end

         if (store_int_to_tmp) begin
            tmp_tdata_reg <= s_eth.tdata[DATA_WIDTH-1:0];
            tmp_tkeep_reg <= s_eth.tkeep[KEEP_WIDTH-1:0];
            tmp_tlast_reg <= s_eth.tlast[0];
            tmp_tuser_reg <= s_eth.tuser[USER_WIDTH-1:0];
         end
      end
   end

   assign s_eth.hdr_ready = hdr_ready_reg;
   assign s_eth.tready    = tready_int_reg && (state_reg == ST_FRAME);

   assign m_eth.hdr_valid = hdr_valid_reg;
   assign m_eth.dest_mac  = {M_COUNT{dest_mac_reg}};
   assign m_eth.src_mac   = {M_COUNT{src_mac_reg}};
   assign m_eth.eth_type  = {M_COUNT{eth_type_reg}};
   assign m_eth.tdata     = {M_COUNT{out_tdata_reg}};
   assign m_eth.tkeep     = KEEP_ENABLE ? {M_COUNT{out_tkeep_reg}} : '1;
   assign m_eth.tvalid    = out_tvalid_reg;
   assign m_eth.tlast     = {M_COUNT{out_tlast_reg}};
   assign m_eth.tuser     = USER_ENABLE ? {M_COUNT{out_tuser_reg}} : '0;

endmodule

// File: tb/tb_eth_demux.sv
// Scoreboard bench for eth_demux (M_COUNT=4, 8-bit payload): routing, back-to-back frames, backpressure, enable gating, reset mid-frame.
// The drop-frame case is exercised only when ETH_DEMUX_DROP_EN is defined.
module tb_eth_demux;
   typedef struct packed {
      logic [1:0]  port;
      logic [7:0]  data;
      logic        last;
      logic        user;
      logic [31:0] cyc;
   } beat_t;

   typedef struct packed {
      logic [1:0]  port;
      logic [47:0] dmac;
   } hdr_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] sel_in;
`ifdef ETH_DEMUX_DROP_EN
   logic       drop_in;
`endif

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    beats_in = 0;
   int    bp_hits = 0;
   logic  lat_chk = 1'b0;
   logic  bp_mode = 1'b0;
   beat_t bq[$];
   hdr_t  hq[$];

   eth_demux_if #(.N(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) s_if ();
   eth_demux_if #(.N(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) m_if ();

   eth_demux #(
      .M_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(0), .KEEP_WIDTH(1),
      .USER_ENABLE(1), .USER_WIDTH(1)
   ) dut (
      .clk(clk), .rst(rst), .s_eth(s_if), .m_eth(m_if),
      .enable(enable), .select(sel_in)
`ifdef ETH_DEMUX_DROP_EN
      , .drop(drop_in)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Readies for the output side: all high, or port 0 toggling 1,0,0,1 during the backpressure test.
   initial begin
      logic [3:0] pat;
      int k;
      pat = 4'b1001;
      k = 0;
      m_if.tready = '1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            m_if.tready = {3'b111, pat[k % 4]};
            k++;
         end else begin
            m_if.tready = '1;
         end
      end
   end

   // Output monitor: pops the scoreboard on every header/beat handshake.
   always @(negedge clk) begin
      static logic prev_mtr0 = 1'b1, prev_xfer = 1'b0, prev_outv0 = 1'b0;
      beat_t b;
      hdr_t  h;
      for (int p = 0; p < 4; p++) begin
         if (m_if.hdr_valid[p] && m_if.hdr_ready[p]) begin
            chk("hdr_expected", hq.size() != 0, 1);
            if (hq.size() != 0) begin
               h = hq.pop_front();
               chk("hdr_port", p, h.port);
               chk("hdr_dmac", m_if.dest_mac[p*48 +: 48], h.dmac);
               chk("hdr_type", m_if.eth_type[p*16 +: 16], 16'h0800);
            end
         end
         if (m_if.tvalid[p] && m_if.tready[p]) begin
            chk("beat_expected", bq.size() != 0, 1);
            if (bq.size() != 0) begin
               b = bq.pop_front();
               chk("beat_port", p, b.port);
               chk("beat_data", m_if.tdata[p*8 +: 8], b.data);
               chk("beat_last", m_if.tlast[p], b.last);
               chk("beat_user", m_if.tuser[p], b.user);
               chk("beat_keep", m_if.tkeep, 4'hF);
               if (lat_chk) chk("beat_latency", cyc, b.cyc + 1);
            end
         end
      end
      if (|m_if.tvalid) chk("tvalid_onehot", $countones(m_if.tvalid), 1);
      if (bp_mode && !prev_mtr0 && prev_xfer && prev_outv0) begin
         bp_hits++;
         chk("bp_tready_drop", s_if.tready, 0);
      end
      prev_mtr0  = m_if.tready[0];
      prev_xfer  = s_if.tvalid[0] && s_if.tready[0];
      prev_outv0 = m_if.tvalid[0];
   end

   task automatic send_hdr(input logic [1:0] sel, input logic [47:0] dmac, input logic drp,
                           output int hcyc);
      int w;
      s_if.hdr_valid = 1'b1;
      s_if.dest_mac  = dmac;
      s_if.src_mac   = 48'h112233445566;
      s_if.eth_type  = 16'h0800;
      sel_in         = sel;
`ifdef ETH_DEMUX_DROP_EN
      drop_in        = drp;
`endif
      w = 0;
      do begin @(negedge clk); w++; end while (!s_if.hdr_ready[0] && w < 200);
      if (!s_if.hdr_ready[0]) chk("hdr_timeout", w, 0);
      hcyc = cyc;
      if (!drp) hq.push_back('{sel, dmac});
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      sel_in         = ~sel;
`ifdef ETH_DEMUX_DROP_EN
      drop_in        = 1'b0;
`endif
   endtask

   task automatic send_payload(input int n, input logic [7:0] base, input logic [1:0] port,
                               input logic drp, output int fcyc, output int lcyc);
      int w;
      fcyc = 0;
      lcyc = 0;
      for (int i = 0; i < n; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = base + 8'(i);
         s_if.tlast  = (i == n - 1);
         s_if.tuser  = s_if.tdata[0];
         w = 0;
         do begin @(negedge clk); w++; end while (!s_if.tready[0] && w < 200);
         if (!s_if.tready[0]) begin
            chk("beat_timeout", w, 0);
            break;
         end
         if (i == 0) fcyc = cyc;
         lcyc = cyc;
         beats_in++;
         if (!drp) bq.push_back('{port, s_if.tdata, s_if.tlast[0], s_if.tuser[0], cyc});
         @(posedge clk); #1;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((bq.size() != 0 || hq.size() != 0) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", bq.size() + hq.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int hc, hc2, fc, lc, fc2, lc2, start, n0;
      rst = 1'b1;
      enable = 1'b1;
      sel_in = 2'd0;
`ifdef ETH_DEMUX_DROP_EN
      drop_in = 1'b0;
`endif
      s_if.hdr_valid = 1'b0;
      s_if.dest_mac = '0;
      s_if.src_mac = '0;
      s_if.eth_type = '0;
      s_if.tdata = '0;
      s_if.tkeep = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      s_if.tuser = 1'b0;
      m_if.hdr_ready = '1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hdr_ready", s_if.hdr_ready, 0);
      chk("rst_tready", s_if.tready, 0);
      chk("rst_m_hdr_valid", m_if.hdr_valid, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_m_tdata", m_if.tdata, 0);
      chk("rst_m_dest_mac", m_if.dest_mac[47:0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tready", s_if.tready, 0);
      @(posedge clk); #1;

      // Single frame to port 2 with latency checks.
      lat_chk = 1'b1;
      start = cyc;
      send_hdr(2'd2, 48'h0A0B0C0D0E0F, 1'b0, hc);
      chk("hdr_ready_latency", hc, start + 1);
      send_payload(5, 8'h01, 2'd2, 1'b0, fc, lc);
      chk("sustained_rate", lc - fc, 4);
      drain();

      // Back-to-back frames; select for frame 2 is presented while frame 1 runs.
      send_hdr(2'd1, 48'h000000000011, 1'b0, hc);
      fork
         send_payload(4, 8'h10, 2'd1, 1'b0, fc, lc);
         send_hdr(2'd3, 48'h000000000033, 1'b0, hc2);
      join
      send_payload(4, 8'h20, 2'd3, 1'b0, fc2, lc2);
      chk("b2b_hdr_cycle", hc2, lc + 1);
      chk("b2b_payload_gap", fc2, lc + 2);
      drain();
      lat_chk = 1'b0;

      // Backpressure on port 0.
      send_hdr(2'd0, 48'h000000000100, 1'b0, hc);
      bp_mode = 1'b1;
      send_payload(6, 8'h30, 2'd0, 1'b0, fc, lc);
      drain();
      bp_mode = 1'b0;
      chk("bp_exercised", bp_hits > 0, 1);
      drain();

      // Enable gating.
      enable = 1'b0;
      s_if.hdr_valid = 1'b1;
      s_if.dest_mac = 48'h0000000000E1;
      s_if.eth_type = 16'h0800;
      sel_in = 2'd1;
      repeat (10) begin
         @(negedge clk);
         chk("enable_low_ready", s_if.hdr_ready, 0);
      end
      @(posedge clk); #1;
      enable = 1'b1;
      hq.push_back('{2'd1, 48'h0000000000E1});
      @(negedge clk);
      chk("enable_rise_same", s_if.hdr_ready, 0);
      @(negedge clk);
      chk("enable_rise_next", s_if.hdr_ready, 1);
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      send_payload(3, 8'h50, 2'd1, 1'b0, fc, lc);
      drain();

`ifdef ETH_DEMUX_DROP_EN
      // Dropped frame: consumed silently, next frame routes normally.
      n0 = beats_in;
      send_hdr(2'd1, 48'h0000000000D0, 1'b1, hc);
      send_payload(4, 8'h60, 2'd1, 1'b1, fc, lc);
      chk("drop_consumed", beats_in - n0, 4);
      repeat (4) @(posedge clk); #1;
      send_hdr(2'd1, 48'h0000000000D1, 1'b0, hc);
      send_payload(3, 8'h68, 2'd1, 1'b0, fc, lc);
      drain();
`endif

      // Reset asserted at beat 3 of a 6-beat frame.
      send_hdr(2'd0, 48'h0000000000F0, 1'b0, hc);
      for (int i = 0; i < 2; i++) begin
         int w;
         s_if.tvalid = 1'b1;
         s_if.tdata = 8'h71 + 8'(i);
         s_if.tlast = 1'b0;
         s_if.tuser = s_if.tdata[0];
         w = 0;
         do begin @(negedge clk); w++; end while (!s_if.tready[0] && w < 200);
         chk("rst_frame_beat_ready", s_if.tready, 1);
         bq.push_back('{2'd0, s_if.tdata, 1'b0, s_if.tuser[0], cyc});
         @(posedge clk); #1;
      end
      s_if.tdata = 8'h73;
      s_if.tuser = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      s_if.tvalid = 1'b0;
      @(negedge clk);
      chk("midrst_m_tvalid", m_if.tvalid, 0);
      chk("midrst_m_hdr_valid", m_if.hdr_valid, 0);
      chk("midrst_m_tdata", m_if.tdata, 0);
      chk("midrst_m_tlast", m_if.tlast, 0);
      chk("midrst_hdr_ready", s_if.hdr_ready, 0);
      chk("midrst_tready", s_if.tready, 0);
      chk("midrst_queue", bq.size(), 0);
      @(posedge clk); #1;
      send_hdr(2'd0, 48'h0000000000F1, 1'b0, hc);
      send_payload(6, 8'h80, 2'd0, 1'b0, fc, lc);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
